// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, special instruction encodings and
// the fetch-stage state type.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 5;

    localparam logic [INSTR_W-1:0] CPU_HALT_INSTR = 16'hFFFF;
    localparam logic [INSTR_W-1:0] CPU_NOP_INSTR  = 16'h0000;

    typedef enum logic {
        FETCH_RUN,
        FETCH_HALT
    } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Next-PC select for the fetch stage: redirect beats hold, hold beats increment.
module pc_next
    import cpu_pkg::*;
#(
    parameter int r = ADDR_W
) (
    input  logic [r-1:0] pc_i,
    input  logic         redirect_i,
    input  logic [r-1:0] redirect_pc_i,
    input  logic         hold_i,
    output logic [r-1:0] pc_d_o
);

    always_comb begin
        pc_d_o = pc_i + r'(1);  // wraps modulo 2^r silently
        if (redirect_i) begin
            pc_d_o = redirect_pc_i;
        end else if (hold_i) begin
            pc_d_o = pc_i;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and
// registers the returned word into IF/ID; supports stall, redirect and HALT.
module ifetch
    import cpu_pkg::*;
#(
    parameter int               n          = INSTR_W,
    parameter int               r          = ADDR_W,
    parameter logic [r-1:0]     RESET_PC   = '0,
    parameter logic [n-1:0]     HALT_INSTR = CPU_HALT_INSTR,
    parameter logic [n-1:0]     NOP_INSTR  = CPU_NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [r-1:0] imem_addr,
    input  logic [n-1:0] imem_data,
    input  logic         stall,
    input  logic         redirect,
    input  logic [r-1:0] redirect_pc,
    output logic [n-1:0] if_instr,
    output logic [r-1:0] if_pc,
    output logic         if_valid,
    output logic         halted
);

    fetch_state_e state_q;
    logic [r-1:0] pc_q;
    logic [r-1:0] pc_d;
    logic [n-1:0] if_instr_q;
    logic [r-1:0] if_pc_q;
    logic         if_valid_q;
    logic         is_halt_instr;
    logic         pc_hold;

    assign is_halt_instr = (imem_data == HALT_INSTR);
    // The PC parks on the HALT word itself, and stays parked while halted.
    assign pc_hold = stall || (state_q == FETCH_HALT) || is_halt_instr;

    pc_next #(.r(r)) u_pc_next (
        .pc_i          (pc_q),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .hold_i        (pc_hold),
        .pc_d_o        (pc_d)
    );

    // NOTE: every register here is updated with <= so all next-state terms see
    // pre-edge values, and the async reset branch clears them without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_RUN;
            pc_q       <= RESET_PC;
            if_instr_q <= NOP_INSTR;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
        end else if (redirect) begin
            state_q    <= FETCH_RUN;
            pc_q       <= pc_d;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
        end else if (stall) begin
            pc_q       <= pc_d;
        end else if (state_q == FETCH_RUN) begin
            pc_q       <= pc_d;
            if_instr_q <= imem_data;
            if_pc_q    <= pc_q;
            if_valid_q <= 1'b1;
            if (is_halt_instr) begin
                state_q <= FETCH_HALT;
            end
        end else begin
            pc_q       <= pc_d;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
        end
    end

    assign imem_addr = pc_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_valid  = if_valid_q;
    assign halted    = (state_q == FETCH_HALT);

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a 32-word ROM model and per-scenario tasks that
// compare {if_instr, if_pc, if_valid, halted, imem_addr} against hand-derived values.
module tb_ifetch;

    logic        clk;
    logic        rst_n;
    logic [4:0]  imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [4:0]  redirect_pc;
    logic [15:0] if_instr;
    logic [4:0]  if_pc;
    logic        if_valid;
    logic        halted;

    logic [15:0] rom [32];
    logic [27:0] obs;
    logic [27:0] exp_v;
    int          vectors;
    int          miscompares;

    ifetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_valid    (if_valid),
        .halted      (halted)
    );

    assign imem_data = rom[imem_addr];
    assign obs = {if_instr, if_pc, if_valid, halted, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        #1;
        exp_v = {16'h0000, 5'd0, 1'b0, 1'b0, 5'd0};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL reset_t0 got %h want %h", obs, exp_v); end
        tick();
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL reset_held got %h want %h", obs, exp_v); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        tick();
        exp_v = {16'h1111, 5'd0, 1'b1, 1'b0, 5'd1};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL run_e1 got %h want %h", obs, exp_v); end
        tick();
        exp_v = {16'h2222, 5'd1, 1'b1, 1'b0, 5'd2};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL run_e2 got %h want %h", obs, exp_v); end
        tick();
        exp_v = {16'h3333, 5'd2, 1'b1, 1'b0, 5'd3};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL run_e3 got %h want %h", obs, exp_v); end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        stall = 1'b1;
        exp_v = {16'h2222, 5'd1, 1'b1, 1'b0, 5'd2};
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (obs !== exp_v) begin miscompares++; $display("FAIL stall_hold%0d got %h want %h", i, obs, exp_v); end
        end
        stall = 1'b0;
        tick();
        exp_v = {16'h3333, 5'd2, 1'b1, 1'b0, 5'd3};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL stall_release got %h want %h", obs, exp_v); end
    endtask

    task automatic test_redirect_over_stall();
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 5'd20;
        tick();
        exp_v = {16'h0000, 5'd2, 1'b0, 1'b0, 5'd20};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL redir_flush got %h want %h", obs, exp_v); end
        stall = 1'b0;
        redirect = 1'b0;
        tick();
        exp_v = {16'h2020, 5'd20, 1'b1, 1'b0, 5'd21};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL redir_target got %h want %h", obs, exp_v); end
    endtask

    task automatic test_halt();
        redirect = 1'b1;
        redirect_pc = 5'd3;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        exp_v = {16'h5555, 5'd4, 1'b1, 1'b0, 5'd5};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL halt_pre got %h want %h", obs, exp_v); end
        tick();
        exp_v = {16'hFFFF, 5'd5, 1'b1, 1'b1, 5'd5};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL halt_capture got %h want %h", obs, exp_v); end
        exp_v = {16'h0000, 5'd5, 1'b0, 1'b1, 5'd5};
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (obs !== exp_v) begin miscompares++; $display("FAIL halt_idle%0d got %h want %h", i, obs, exp_v); end
        end
        redirect = 1'b1;
        redirect_pc = 5'd0;
        tick();
        redirect = 1'b0;
        exp_v = {16'h0000, 5'd5, 1'b0, 1'b0, 5'd0};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL halt_exit got %h want %h", obs, exp_v); end
        tick();
        exp_v = {16'h1111, 5'd0, 1'b1, 1'b0, 5'd1};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL halt_resume got %h want %h", obs, exp_v); end
    endtask

    task automatic test_halt_deferred_by_stall();
        redirect = 1'b1;
        redirect_pc = 5'd5;
        tick();
        redirect = 1'b0;
        stall = 1'b1;
        tick();
        exp_v = {16'h0000, 5'd0, 1'b0, 1'b0, 5'd5};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL halt_deferred got %h want %h", obs, exp_v); end
        stall = 1'b0;
        tick();
        exp_v = {16'hFFFF, 5'd5, 1'b1, 1'b1, 5'd5};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL halt_after_stall got %h want %h", obs, exp_v); end
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 5'd0;
        tick();
        stall = 1'b0;
        redirect = 1'b0;
        exp_v = {16'h0000, 5'd5, 1'b0, 1'b0, 5'd0};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL halt_exit_stalled got %h want %h", obs, exp_v); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirect_pc = 5'd30;
        tick();
        redirect = 1'b0;
        tick();
        exp_v = {16'hA01E, 5'd30, 1'b1, 1'b0, 5'd31};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL wrap_30 got %h want %h", obs, exp_v); end
        tick();
        exp_v = {16'h3131, 5'd31, 1'b1, 1'b0, 5'd0};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL wrap_31 got %h want %h", obs, exp_v); end
        tick();
        exp_v = {16'h1111, 5'd0, 1'b1, 1'b0, 5'd1};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL wrap_0 got %h want %h", obs, exp_v); end
    endtask

    task automatic test_async_reset();
        redirect = 1'b1;
        redirect_pc = 5'd6;
        tick();
        redirect = 1'b0;
        tick();
        exp_v = {16'hA006, 5'd6, 1'b1, 1'b0, 5'd7};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL areset_pre got %h want %h", obs, exp_v); end
        #2;
        rst_n = 1'b0;
        #1;
        exp_v = {16'h0000, 5'd0, 1'b0, 1'b0, 5'd0};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL areset_now got %h want %h", obs, exp_v); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp_v = {16'h1111, 5'd0, 1'b1, 1'b0, 5'd1};
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL areset_restart got %h want %h", obs, exp_v); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 32; i++) rom[i] = 16'hA000 + 16'(i);
        rom[0]  = 16'h1111;
        rom[1]  = 16'h2222;
        rom[2]  = 16'h3333;
        rom[3]  = 16'h4444;
        rom[4]  = 16'h5555;
        rom[5]  = 16'hFFFF;
        rom[20] = 16'h2020;
        rom[31] = 16'h3131;

        test_reset();
        test_free_run();
        test_stall();
        test_redirect_over_stall();
        test_halt();
        test_halt_deferred_by_stall();
        test_wrap();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
